// File: rtl/tx_byte_serializer.sv
// tx_byte_serializer: FIFO-buffered byte-to-bit serializer with idle-symbol fill
// and a startup sync phase of MIN_SYNC idle symbols.
module tx_byte_serializer #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] IDLE_SYM  = 8'hBC,
    parameter int         MIN_SYNC  = 4,
    parameter bit         MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [7:0]               data_in,
    input  logic                     valid_in,
    output logic                     serial_out,
    output logic                     bit_valid,
    output logic                     sym_start,
    output logic                     active,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(MIN_SYNC + 1);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] SYNC_LAST = SW'(MIN_SYNC - 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_SYNC = 2'd1, S_ACT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          dv_q, dv_d;
    logic          stop_q, stop_d;
    logic [SW-1:0] sync_q, sync_d;
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q;
    logic [7:0]    mem [DEPTH];
    logic          wr, bnd, leave, pop;

    always_comb begin
        wr      = valid_in && count_q != FULL;
        bnd     = state_q != S_IDLE && cnt_q == 3'd7;
        leave   = stop_q || !enable;
        pop     = bnd && state_q == S_ACT && !leave && count_q != '0;
        count_d = count_q + (AW+1)'(wr) - (AW+1)'(pop);
        state_d = state_q;
        cnt_d   = state_q == S_IDLE ? 3'd0 : cnt_q + 3'd1;
        sh_d    = MSB_FIRST ? {sh_q[6:0], 1'b0} : {1'b0, sh_q[7:1]};
        dv_d    = dv_q;
        sync_d  = sync_q;
        // a disable request is latched so a late re-enable cannot cancel the return to IDLE
        stop_d  = stop_q | (state_q != S_IDLE && !enable);
        if (state_q == S_IDLE) begin
            stop_d  = 1'b0;
            dv_d    = 1'b0;
            sh_d    = enable ? IDLE_SYM : 8'h00;
            state_d = enable ? S_SYNC : S_IDLE;
        end else if (bnd && leave) begin
            state_d = S_IDLE;
            sh_d    = 8'h00;
            dv_d    = 1'b0;
            sync_d  = '0;
            stop_d  = 1'b0;
        end else if (bnd && state_q == S_SYNC) begin
            sh_d    = IDLE_SYM;
            dv_d    = 1'b0;
            sync_d  = sync_q == SYNC_LAST ? '0 : sync_q + SW'(1);
            state_d = sync_q == SYNC_LAST ? S_ACT : S_SYNC;
        end else if (bnd) begin
            sh_d = pop ? mem[rp_q] : IDLE_SYM;
            dv_d = pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp_q] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            sh_q    <= 8'h00;
            dv_q    <= 1'b0;
            stop_q  <= 1'b0;
            sync_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            dv_q    <= dv_d;
            stop_q  <= stop_d;
            sync_q  <= sync_d;
            wp_q    <= wr ? wp_q + AW'(1) : wp_q;
            rp_q    <= pop ? rp_q + AW'(1) : rp_q;
            count_q <= count_d;
            ovf_q   <= ovf_q | (valid_in && !wr);
        end
    end

    assign serial_out = MSB_FIRST ? sh_q[7] : sh_q[0];
    assign bit_valid  = dv_q;
    assign sym_start  = state_q != S_IDLE && cnt_q == 3'd0;
    assign active     = state_q == S_ACT;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_tx_byte_serializer.sv
// tb_tx_byte_serializer: symbol-level reference model feeding a per-cycle output
// scoreboard and an in-order byte delivery scoreboard.
module tb_tx_byte_serializer;
    localparam int         DEPTH     = 8;
    localparam logic [7:0] IDLE_SYM  = 8'hBC;
    localparam int         MIN_SYNC  = 4;
    localparam bit         MSB_FIRST = 1'b0;
    localparam int         CW        = $clog2(DEPTH) + 1;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic serial_out, bit_valid, sym_start, active, overflow;
    logic [CW-1:0] fifo_count;

    tx_byte_serializer #(.DEPTH(DEPTH), .IDLE_SYM(IDLE_SYM), .MIN_SYNC(MIN_SYNC), .MSB_FIRST(MSB_FIRST)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in), .valid_in(valid_in),
        .serial_out(serial_out), .bit_valid(bit_valid), .sym_start(sym_start), .active(active),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // model: link phase (0 idle, 1 sync, 2 active), position inside current symbol, FIFO as a queue
    int         m_phase = 0, m_pos = 0, m_nsync = 0;
    logic [7:0] m_sym = 8'h00;
    bit         m_data = 0, m_stop = 0, m_ovf = 0;
    logic [7:0] fq [$];
    logic [7:0] exp_bytes [$];
    logic [CW+4:0] sb [$];

    task automatic model_step();
        bit full;
        if (reset) begin
            m_phase = 0; m_pos = 0; m_nsync = 0; m_sym = 8'h00;
            m_data = 0; m_stop = 0; m_ovf = 0;
            fq.delete(); exp_bytes.delete();
        end else begin
            full = fq.size() == DEPTH;
            if (m_phase == 0) begin
                m_pos = 0; m_data = 0; m_stop = 0;
                m_sym = enable ? IDLE_SYM : 8'h00;
                if (enable) m_phase = 1;
            end else if (m_pos < 7) begin
                m_pos++;
                if (!enable) m_stop = 1;
            end else begin
                m_pos = 0;
                if (m_stop || !enable) begin
                    m_phase = 0; m_sym = 8'h00; m_data = 0; m_nsync = 0; m_stop = 0;
                end else if (m_phase == 1) begin
                    m_sym = IDLE_SYM; m_data = 0; m_nsync++;
                    if (m_nsync == MIN_SYNC) begin m_phase = 2; m_nsync = 0; end
                end else if (fq.size() > 0) begin
                    m_sym = fq.pop_front(); m_data = 1;
                    exp_bytes.push_back(m_sym);
                end else begin
                    m_sym = IDLE_SYM; m_data = 0;
                end
            end
            if (valid_in) begin
                if (full) m_ovf = 1;
                else fq.push_back(data_in);
            end
        end
        sb.push_back({(m_phase != 0) ? m_sym[MSB_FIRST ? 7 - m_pos : m_pos] : 1'b0,
                      m_data, m_phase != 0 && m_pos == 0, m_phase == 2, m_ovf, CW'(fq.size())});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // monitor: compares every registered output and reassembles delivered data bytes
    int nb = 0;
    logic [7:0] acc = 8'h00;
    initial forever begin
        logic [CW+4:0] e, a;
        logic [7:0] want;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {serial_out, bit_valid, sym_start, active, overflow, fifo_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got ser=%b bv=%b ss=%b act=%b ovf=%b cnt=%0d want ser=%b bv=%b ss=%b act=%b ovf=%b cnt=%0d",
                         $time, a[CW+4], a[CW+3], a[CW+2], a[CW+1], a[CW], a[CW-1:0],
                         e[CW+4], e[CW+3], e[CW+2], e[CW+1], e[CW], e[CW-1:0]);
            end
        end
        if (reset || sym_start) nb = 0;
        if (!reset && bit_valid) begin
            acc = MSB_FIRST ? {acc[6:0], serial_out} : {serial_out, acc[7:1]};
            nb++;
            if (nb == 8) begin
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL byte t=%0t got %h want none", $time, acc);
                end else begin
                    want = exp_bytes.pop_front();
                    if (acc !== want) begin
                        errors++;
                        $display("FAIL byte t=%0t got %h want %h", $time, acc, want);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int left;
        repeat (3) step();
        reset = 1'b0;
        enable = 1'b1;
        repeat (60) step();
        valid_in = 1'b1; data_in = 8'hA5;
        step();
        valid_in = 1'b0;
        repeat (30) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            valid_in = 1'b1; data_in = 8'(i);
            step();
        end
        valid_in = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fifo_count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL burst_full got ovf=%b cnt=%0d want ovf=1 cnt=%0d", overflow, fifo_count, DEPTH);
        end
        repeat (120) step();
        for (int i = 0; i < 3000; i++) begin
            valid_in = ($urandom % 4) == 0;
            data_in  = 8'($urandom);
            if ($urandom % 150 == 0) enable = ~enable;
            if (!enable && $urandom % 12 == 0) enable = 1'b1;
            reset = ($urandom % 600) == 0;
            step();
        end
        reset = 1'b0; valid_in = 1'b0; enable = 1'b1;
        left = 400;
        while (left > 0 && (fq.size() + exp_bytes.size()) != 0) begin
            step();
            left--;
        end
        checks++;
        if ((fq.size() + exp_bytes.size()) != 0) begin
            errors++;
            $display("FAIL drain got %0d bytes pending want 0", fq.size() + exp_bytes.size());
        end
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
